credit_sender: RTL and testbench

Upstream neighbour of the credit-based receiver on a point-to-point metro link. Accepts 64-bit flits from a local producer over a valid/ready interface and buffers them in a small FIFO. Forwards one flit per cycle onto the link (valid_o/data_o) only while it holds a credit. Regains one credit per yummy_i pulse returned by the downstream receiver.

---
 rtl/credit_sender.sv | 175 +++++++++++++++++
 tb/tb_credit_sender.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sender.sv
// credit_sender
// Upstream side of a credit-based point-to-point link. Flits from a local
// producer (valid/ready) are buffered in a small circular FIFO. The head flit
// is forwarded onto the link, one per cycle, only while a credit is held.
// Each yummy_i pulse from the downstream receiver returns one credit.
//
// Parameters:
//   CREDITS    initial and maximum credit count (downstream buffer slots)
//   FIFO_DEPTH local buffer entries, power of two, >= 2
//   DATA_WIDTH flit width
//
// Ports:
//   clk_i    clock, all state updates on posedge
//   rst_i    synchronous active-high reset
//   valid_i  producer flit valid
//   data_i   producer flit
//   ready_o  FIFO not full (registered occupancy, no pop bypass)
//   valid_o  link flit valid, one cycle per flit
//   data_o   link flit, holds last value when valid_o is low
//   yummy_i  credit return, one credit per high cycle
//   credit_o current credit count
//   state_o  0 IDLE, 1 ACTIVE, 2 BLOCKED
//   err_o    sticky credit-overflow flag
//
// Optional feature macro: METRO_SENDER_CREDIT_CHECK_EN
//   defined   : err_o latches high the cycle after an overflowing yummy_i and
//               a message is printed for each occurrence.
//   undefined : err_o is tied low; overflow is silently saturated.

module credit_sender #(
  parameter int CREDITS    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic                           ready_o,
  output logic                           valid_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  input  logic                           yummy_i,
  output logic [$clog2(CREDITS+1)-1:0]   credit_o,
  output logic [1:0]                     state_o,
  output logic                           err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDITS+1);
  localparam logic [CW-1:0] CREDITS_C = CW'(CREDITS);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  // FIFO storage and pointers (index plus one wrap bit)
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           fifo_count_d;
  logic                  fifo_empty;
  logic                  fifo_full;

  logic [CW-1:0]         credit_q, credit_d;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  state_t                state_q, state_d;

  logic                  push;
  logic                  send;
  logic                  overflow;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Acceptance looks only at registered occupancy, so a full FIFO refuses a
  // flit even in a cycle where the head is leaving.
  assign push = valid_i && !fifo_full;
  // Send decision uses registered state only: no yummy-to-valid path.
  assign send = !fifo_empty && (credit_q != '0);

  assign wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d     = send ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign fifo_count_d = wr_ptr_d - rd_ptr_d;

  // Credit update: send consumes one, yummy returns one; both cancel.
  // A yummy with the counter already full and no send is an overflow and
  // saturates instead of wrapping.
  always_comb begin
    credit_d = credit_q;
    overflow = 1'b0;
    if (send && !yummy_i) begin
      credit_d = credit_q - ONE_C;
    end else if (!send && yummy_i) begin
      if (credit_q == CREDITS_C) begin
        overflow = 1'b1;
      end else begin
        credit_d = credit_q + ONE_C;
      end
    end
  end

  // Next state from post-update occupancy and credit.
  always_comb begin
    state_d = ST_IDLE;
    if (fifo_count_d != '0) begin
      if (credit_d != '0) begin
        state_d = ST_ACTIVE;
      end else begin
        state_d = ST_BLOCKED;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= CREDITS_C;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      credit_q <= credit_d;
      valid_q  <= send;
      if (send) begin
        data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

`ifdef METRO_SENDER_CREDIT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (overflow) begin
      err_q <= 1'b1;
      $display("ERROR: credit overflow");
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ready_o  = !fifo_full;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign credit_o = credit_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender. Instance "a" uses CREDITS=1, instance "b" uses
// CREDITS=2. Expected flits go into a per-instance queue when accepted and are
// popped and compared when the link side shows valid_o.

module tb_credit_sender;

  localparam int DW = 64;

  logic clk;

  // instance a: CREDITS = 1
  logic          rst_a, valid_a, yummy_a;
  logic [DW-1:0] data_a;
  logic          ready_a, valid_o_a, err_a;
  logic [DW-1:0] data_o_a;
  logic [0:0]    credit_a;
  logic [1:0]    state_a;

  // instance b: CREDITS = 2
  logic          rst_b, valid_b, yummy_b;
  logic [DW-1:0] data_b;
  logic          ready_b, valid_o_b, err_b;
  logic [DW-1:0] data_o_b;
  logic [1:0]    credit_b;
  logic [1:0]    state_b;

  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];

  int total;
  int pass;

  credit_sender #(.CREDITS(1), .FIFO_DEPTH(4), .DATA_WIDTH(DW)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .valid_i(valid_a), .data_i(data_a),
    .ready_o(ready_a), .valid_o(valid_o_a), .data_o(data_o_a),
    .yummy_i(yummy_a), .credit_o(credit_a), .state_o(state_a), .err_o(err_a)
  );

  credit_sender #(.CREDITS(2), .FIFO_DEPTH(4), .DATA_WIDTH(DW)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .valid_i(valid_b), .data_i(data_b),
    .ready_o(ready_b), .valid_o(valid_o_b), .data_o(data_o_b),
    .yummy_i(yummy_b), .credit_o(credit_b), .state_o(state_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1;
    valid_a = 0; yummy_a = 0; data_a = '0;
    valid_b = 0; yummy_b = 0; data_b = '0;
    cyc(); cyc();
    rst_a = 0; rst_b = 0;
    total++; if (valid_o_a !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid_o_a); else pass++;
    total++; if (ready_a !== 1'b1) $display("FAIL reset_ready got %0b want 1", ready_a); else pass++;
    total++; if (credit_a !== 1'd1) $display("FAIL reset_credit got %0d want 1", credit_a); else pass++;
    total++; if (state_a !== 2'd0) $display("FAIL reset_state got %0d want 0", state_a); else pass++;
    total++; if (err_a !== 1'b0) $display("FAIL reset_err got %0b want 0", err_a); else pass++;
    total++; if (data_o_a !== 64'h0) $display("FAIL reset_data got %h want 0", data_o_a); else pass++;
    total++; if (credit_b !== 2'd2) $display("FAIL reset_credit_b got %0d want 2", credit_b); else pass++;
    $display("reset done");
  endtask

  task automatic test_single_flit();
    logic [DW-1:0] exp;
    valid_a = 1; data_a = 64'hDEADBEEF_00000001;
    q_a.push_back(data_a);
    cyc();  // edge 0: accepted
    valid_a = 0;
    total++; if (valid_o_a !== 1'b0) $display("FAIL single_nobypass got %0b want 0", valid_o_a); else pass++;
    total++; if (state_a !== 2'd1) $display("FAIL single_state_active got %0d want 1", state_a); else pass++;
    cyc();  // edge 1: sent
    total++; if (valid_o_a !== 1'b1) $display("FAIL single_valid got %0b want 1", valid_o_a); else pass++;
    if (valid_o_a === 1'b1 && q_a.size() > 0) begin
      exp = q_a.pop_front();
      $display("tx a data=%h", data_o_a);
      total++; if (data_o_a !== exp) $display("FAIL single_data got %h want %h", data_o_a, exp); else pass++;
    end
    total++; if (credit_a !== 1'd0) $display("FAIL single_credit0 got %0d want 0", credit_a); else pass++;
    total++; if (state_a !== 2'd0) $display("FAIL single_state_idle got %0d want 0", state_a); else pass++;
    cyc();  // edge 2
    total++; if (valid_o_a !== 1'b0) $display("FAIL single_one_cycle got %0b want 0", valid_o_a); else pass++;
    cyc();  // edge 3
    total++; if (credit_a !== 1'd0) $display("FAIL single_credit_held got %0d want 0", credit_a); else pass++;
    yummy_a = 1;
    cyc();  // edge 4: credit returned
    yummy_a = 0;
    total++; if (credit_a !== 1'd1) $display("FAIL single_credit_back got %0d want 1", credit_a); else pass++;
    total++; if (err_a !== 1'b0) $display("FAIL single_err got %0b want 0", err_a); else pass++;
  endtask

  task automatic test_blocked();
    logic [DW-1:0] exp;
    for (int k = 0; k < 5; k++) begin
      valid_a = 1; data_a = 64'(k + 1);
      total++; if (ready_a !== 1'b1) $display("FAIL blk_ready_in%0d got %0b want 1", k, ready_a); else pass++;
      if (ready_a === 1'b1) q_a.push_back(data_a);
      cyc();
      total++; if (valid_o_a !== (k == 1)) $display("FAIL blk_valid_e%0d got %0b want %0b", k, valid_o_a, (k == 1)); else pass++;
      if (valid_o_a === 1'b1 && q_a.size() > 0) begin
        exp = q_a.pop_front();
        $display("tx a data=%h", data_o_a);
        total++; if (data_o_a !== exp) $display("FAIL blk_first_data got %h want %h", data_o_a, exp); else pass++;
      end
    end
    valid_a = 0;
    total++; if (ready_a !== 1'b0) $display("FAIL blk_full_ready got %0b want 0", ready_a); else pass++;
    total++; if (state_a !== 2'd2) $display("FAIL blk_state got %0d want 2", state_a); else pass++;
    total++; if (credit_a !== 1'd0) $display("FAIL blk_credit got %0d want 0", credit_a); else pass++;
    for (int j = 0; j < 4; j++) begin
      yummy_a = 1;
      cyc();
      yummy_a = 0;
      total++; if (valid_o_a !== 1'b0) $display("FAIL blk_yummy_edge%0d got %0b want 0", j, valid_o_a); else pass++;
      total++; if (credit_a !== 1'd1) $display("FAIL blk_credit_up%0d got %0d want 1", j, credit_a); else pass++;
      cyc();
      total++; if (valid_o_a !== 1'b1) $display("FAIL blk_send%0d got %0b want 1", j, valid_o_a); else pass++;
      if (valid_o_a === 1'b1 && q_a.size() > 0) begin
        exp = q_a.pop_front();
        $display("tx a data=%h", data_o_a);
        total++; if (data_o_a !== exp) $display("FAIL blk_data%0d got %h want %h", j, data_o_a, exp); else pass++;
      end
      total++; if (credit_a !== 1'd0) $display("FAIL blk_credit_dn%0d got %0d want 0", j, credit_a); else pass++;
    end
    total++; if (state_a !== 2'd0) $display("FAIL blk_end_state got %0d want 0", state_a); else pass++;
    total++; if (q_a.size() != 0) $display("FAIL blk_leftover got %0d want 0", q_a.size()); else pass++;
  endtask

  task automatic test_back_to_back();
    int sent;
    int outs;
    int first;
    int last;
    logic [DW-1:0] exp;
    sent = 0; outs = 0; first = -1; last = -1;
    yummy_b = 0;
    for (int c = 0; c < 40 && outs < 8; c++) begin
      if (sent < 8) begin
        valid_b = 1; data_b = 64'h100 + 64'(sent);
        total++; if (ready_b !== 1'b1) $display("FAIL b2b_ready%0d got %0b want 1", sent, ready_b); else pass++;
        if (ready_b === 1'b1) begin
          q_b.push_back(data_b);
          sent++;
        end
      end else begin
        valid_b = 0;
      end
      cyc();
      // downstream returns one credit the edge after each received flit
      yummy_b = valid_o_b;
      if (valid_o_b === 1'b1) begin
        $display("tx b data=%h credit=%0d", data_o_b, credit_b);
        if (q_b.size() == 0) begin
          total++; $display("FAIL b2b_unexpected got %h want none", data_o_b);
        end else begin
          exp = q_b.pop_front();
          total++; if (data_o_b !== exp) $display("FAIL b2b_data got %h want %h", data_o_b, exp); else pass++;
        end
        total++; if (credit_b !== 2'd1) $display("FAIL b2b_credit got %0d want 1", credit_b); else pass++;
        if (first < 0) first = c;
        last = c;
        outs++;
      end
    end
    valid_b = 0;
    cyc();
    yummy_b = 0;
    total++; if (outs != 8) $display("FAIL b2b_count got %0d want 8", outs); else pass++;
    total++; if (last - first != 7) $display("FAIL b2b_bubbles got span %0d want 7", last - first); else pass++;
    total++; if (credit_b !== 2'd2) $display("FAIL b2b_credit_end got %0d want 2", credit_b); else pass++;
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 3; k++) begin
      valid_a = 1; data_a = 64'hA0 + 64'(k + 1);
      cyc();
    end
    valid_a = 0;
    total++; if (state_a !== 2'd2) $display("FAIL mid_pre_state got %0d want 2", state_a); else pass++;
    rst_a = 1; yummy_a = 1;
    cyc();
    rst_a = 0; yummy_a = 0;
    q_a.delete();
    total++; if (credit_a !== 1'd1) $display("FAIL mid_credit got %0d want 1", credit_a); else pass++;
    total++; if (valid_o_a !== 1'b0) $display("FAIL mid_valid got %0b want 0", valid_o_a); else pass++;
    total++; if (ready_a !== 1'b1) $display("FAIL mid_ready got %0b want 1", ready_a); else pass++;
    total++; if (state_a !== 2'd0) $display("FAIL mid_state got %0d want 0", state_a); else pass++;
    for (int k = 0; k < 6; k++) begin
      cyc();
      total++; if (valid_o_a !== 1'b0) $display("FAIL mid_stale%0d got %0b want 0 data %h", k, valid_o_a, data_o_a); else pass++;
    end
  endtask

  task automatic test_overflow();
    yummy_a = 1;
    cyc();
    yummy_a = 0;
    total++; if (credit_a !== 1'd1) $display("FAIL ovf_credit got %0d want 1", credit_a); else pass++;
`ifdef METRO_SENDER_CREDIT_CHECK_EN
    total++; if (err_a !== 1'b1) $display("FAIL ovf_err got %0b want 1", err_a); else pass++;
    cyc(); cyc();
    total++; if (err_a !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", err_a); else pass++;
`else
    total++; if (err_a !== 1'b0) $display("FAIL ovf_err got %0b want 0", err_a); else pass++;
    cyc(); cyc();
    total++; if (err_a !== 1'b0) $display("FAIL ovf_err_hold got %0b want 0", err_a); else pass++;
`endif
    total++; if (credit_a !== 1'd1) $display("FAIL ovf_credit_hold got %0d want 1", credit_a); else pass++;
  endtask

  initial begin
    total = 0;
    pass  = 0;
    test_reset();
    test_single_flit();
    test_blocked();
    test_back_to_back();
    test_reset_midstream();
    test_overflow();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
